// File: rtl/cci_mpf_prim_rob_alloc_arb_if.sv
// Request/response and ROB enq/deq control bundle for the ROB allocation arbiter.
// The arbiter connects through the slave modport; the environment (clients and ROB) uses master.
interface cci_mpf_prim_rob_alloc_arb_if #(
    parameter int N_REQ       = 4,
    parameter int N_ENTRIES   = 32,
    parameter int N_META_BITS = 8
);
    localparam int IDX_W  = $clog2(N_ENTRIES);
    localparam int ID_W   = $clog2(N_REQ);
    localparam int META_W = ID_W + N_META_BITS;

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ*N_META_BITS-1:0] req_meta;
    logic [N_REQ-1:0]             req_grant;
    logic [IDX_W-1:0]             grant_idx;
    logic                         rob_enq_en;
    logic [META_W-1:0]            rob_enqMeta;
    logic                         rob_notFull;
    logic [IDX_W-1:0]             rob_enqIdx;
    logic                         rob_deq_en;
    logic                         rob_notEmpty;
    logic [META_W-1:0]            rob_firstMeta;
    logic [N_REQ-1:0]             rsp_valid;
    logic [N_META_BITS-1:0]       rsp_meta;
    logic [N_REQ-1:0]             rsp_ready;
    logic                         busy;

    modport slave (
        input  req_valid, req_meta, rob_notFull, rob_enqIdx,
               rob_notEmpty, rob_firstMeta, rsp_ready,
        output req_grant, grant_idx, rob_enq_en, rob_enqMeta,
               rob_deq_en, rsp_valid, rsp_meta, busy
    );

    modport master (
        output req_valid, req_meta, rob_notFull, rob_enqIdx,
               rob_notEmpty, rob_firstMeta, rsp_ready,
        input  req_grant, grant_idx, rob_enq_en, rob_enqMeta,
               rob_deq_en, rsp_valid, rsp_meta, busy
    );
endinterface

// File: rtl/cci_mpf_prim_rob_alloc_arb.sv
// Shares one ROB between N_REQ requesters: round-robin slot allocation with a
// per-requester outstanding cap, and head-of-line routing of ROB output to its owner.
module cci_mpf_prim_rob_alloc_arb #(
    parameter int N_REQ           = 4,
    parameter int N_ENTRIES       = 32,
    parameter int N_META_BITS     = 8,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic clk,
    input  logic reset_n,
    cci_mpf_prim_rob_alloc_arb_if.slave bus
);
    localparam int ID_W   = $clog2(N_REQ);
    localparam int META_W = ID_W + N_META_BITS;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);

    logic             run;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] cnt [N_REQ];

    logic             grant_found;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  ci;
    int unsigned      cand;
    logic [N_REQ-1:0] grant;

    logic [ID_W-1:0]  rsp_id;
    logic             deq;
    logic             any_cnt;

    // Pick the first eligible requester at or above rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        win         = '0;
        ci          = '0;
        cand        = 0;
        grant       = '0;
        if (run && bus.rob_notFull) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                cand = (32'(rr_ptr) + k) % N_REQ;
                ci   = cand[ID_W-1:0];
                if (!grant_found && bus.req_valid[ci] &&
                    (cnt[ci] < CNT_W'(MAX_OUTSTANDING))) begin
                    grant_found = 1'b1;
                    win         = ci;
                end
            end
        end
        if (grant_found) begin
            grant[win] = 1'b1;
        end
    end

    // Head-of-line response routing; rsp_valid never looks at rsp_ready.
    always_comb begin
        rsp_id        = bus.rob_firstMeta[META_W-1 -: ID_W];
        deq           = 1'b0;
        bus.rsp_valid = '0;
        bus.rsp_meta  = bus.rob_firstMeta[N_META_BITS-1:0];
        if (run && bus.rob_notEmpty) begin
            bus.rsp_valid[rsp_id] = 1'b1;
            deq                   = bus.rsp_ready[rsp_id];
        end
    end

    // Drive the ROB enqueue side and the busy flag from registered counts.
    always_comb begin
        any_cnt = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            any_cnt = any_cnt | (cnt[i] != '0);
        end
        bus.req_grant   = grant;
        bus.rob_enq_en  = grant_found;
        bus.rob_enqMeta = {win, bus.req_meta[win*N_META_BITS +: N_META_BITS]};
        bus.grant_idx   = bus.rob_enqIdx;
        bus.rob_deq_en  = deq;
        bus.busy        = run && any_cnt;
    end

    // Run flag and round-robin pointer; pointer moves past the winner only on a grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run    <= 1'b0;
            rr_ptr <= '0;
        end else begin
            run <= 1'b1;
            if (grant_found) begin
                rr_ptr <= (32'(win) == N_REQ - 1) ? '0 : win + ID_W'(1);
            end
        end
    end

    // Outstanding counters; a grant and a deq for the same requester cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (grant[i] && !(deq && rsp_id == ID_W'(i))) begin
                    assert (cnt[i] != CNT_W'(MAX_OUTSTANDING));
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (!grant[i] && deq && rsp_id == ID_W'(i)) begin
                    assert (cnt[i] != '0);
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_cci_mpf_prim_rob_alloc_arb.sv
// Bench for the ROB allocation arbiter: a queue-based ROB plus per-requester
// counts predict grants and responses for directed scenarios and a random run.
module tb_cci_mpf_prim_rob_alloc_arb;
    localparam int N_REQ = 4;
    localparam int N_ENTRIES = 32;
    localparam int N_META_BITS = 8;
    localparam int MAX_OUT = 8;

    typedef struct {
        int id;
        int meta;
    } ent_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int total = 0;
    int bad = 0;

    // Reference state
    ent_t q[$];
    int   cnt_m [N_REQ];
    int   rr_m;
    int   tail_m;
    bit   run_m;

    // Predictions for the current cycle
    logic [N_REQ-1:0] exp_grant, exp_rsp_valid;
    logic             exp_enq, exp_deq, exp_busy;
    logic [4:0]       exp_idx;
    logic [9:0]       exp_enqMeta;
    logic [7:0]       exp_rsp_meta;
    int               exp_w, exp_id;

    cci_mpf_prim_rob_alloc_arb_if #(.N_REQ(N_REQ), .N_ENTRIES(N_ENTRIES),
                                    .N_META_BITS(N_META_BITS)) ifc ();

    cci_mpf_prim_rob_alloc_arb #(.N_REQ(N_REQ), .N_ENTRIES(N_ENTRIES),
                                 .N_META_BITS(N_META_BITS),
                                 .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk(clk), .reset_n(reset_n), .bus(ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < N_REQ; i++) cnt_m[i] = 0;
        rr_m = 0;
        tail_m = 0;
        run_m = 0;
    endtask

    task automatic predict();
        int sum;
        exp_grant = '0;
        exp_enq = 1'b0;
        exp_w = 0;
        if (run_m && ifc.rob_notFull) begin
            for (int k = 0; k < N_REQ; k++) begin
                int i;
                i = (rr_m + k) % N_REQ;
                if (!exp_enq && ifc.req_valid[i] && cnt_m[i] < MAX_OUT) begin
                    exp_enq = 1'b1;
                    exp_w = i;
                    exp_grant[i] = 1'b1;
                end
            end
        end
        exp_idx = 5'(tail_m % N_ENTRIES);
        exp_enqMeta = {2'(exp_w), ifc.req_meta[exp_w*8 +: 8]};
        exp_rsp_valid = '0;
        exp_deq = 1'b0;
        exp_id = 0;
        exp_rsp_meta = '0;
        if (run_m && q.size() > 0) begin
            exp_id = q[0].id;
            exp_rsp_valid[exp_id] = 1'b1;
            exp_rsp_meta = 8'(q[0].meta);
            exp_deq = ifc.rsp_ready[exp_id];
        end
        sum = 0;
        for (int i = 0; i < N_REQ; i++) sum += cnt_m[i];
        exp_busy = run_m && (sum > 0);
    endtask

    task automatic check_model();
        predict();
        chk("grant", 64'(ifc.req_grant), 64'(exp_grant));
        chk("enq_en", 64'(ifc.rob_enq_en), 64'(exp_enq));
        chk("deq_en", 64'(ifc.rob_deq_en), 64'(exp_deq));
        chk("rsp_valid", 64'(ifc.rsp_valid), 64'(exp_rsp_valid));
        chk("busy", 64'(ifc.busy), 64'(exp_busy));
        if (exp_enq) begin
            chk("grant_idx", 64'(ifc.grant_idx), 64'(exp_idx));
            chk("enq_meta", 64'(ifc.rob_enqMeta), 64'(exp_enqMeta));
        end
        if (exp_rsp_valid != '0) chk("rsp_meta", 64'(ifc.rsp_meta), 64'(exp_rsp_meta));
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] r, input logic nf,
                         input logic [31:0] meta);
        ifc.req_valid = v;
        ifc.rsp_ready = r;
        ifc.req_meta = meta;
        ifc.rob_notFull = nf && (q.size() < N_ENTRIES);
        ifc.rob_enqIdx = 5'(tail_m % N_ENTRIES);
        ifc.rob_notEmpty = (q.size() > 0);
        ifc.rob_firstMeta = (q.size() > 0) ? {2'(q[0].id), 8'(q[0].meta)} : 10'($urandom);
        #1;
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset_n) begin
            if (run_m) begin
                if (exp_deq) begin
                    cnt_m[exp_id]--;
                    void'(q.pop_front());
                end
                if (exp_enq) begin
                    ent_t e;
                    e.id = exp_w;
                    e.meta = exp_enqMeta[7:0];
                    cnt_m[exp_w]++;
                    q.push_back(e);
                    tail_m++;
                    rr_m = (exp_w + 1) % N_REQ;
                end
            end
            run_m = 1;
        end
        @(negedge clk);
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] r, input logic nf,
                        input logic [31:0] meta);
        drive(v, r, nf, meta);
        advance();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        ifc.req_valid = '0;
        ifc.rsp_ready = '0;
        ifc.req_meta = '0;
        ifc.rob_notFull = 1'b1;
        ifc.rob_enqIdx = '0;
        ifc.rob_notEmpty = 1'b0;
        ifc.rob_firstMeta = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        // T1: single requester, first post-reset cycle idle, then three grants
        do_reset();
        drive(4'b0001, 4'b0000, 1'b1, 32'h11223344);
        chk("t1_no_grant_first", 64'(ifc.req_grant), 64'h0);
        advance();
        for (int k = 0; k < 3; k++) begin
            drive(4'b0001, 4'b0000, 1'b1, 32'($urandom));
            chk("t1_grant", 64'(ifc.req_grant), 64'h1);
            chk("t1_idx", 64'(ifc.grant_idx), 64'(k));
            chk("t1_id", 64'(ifc.rob_enqMeta[9:8]), 64'h0);
            advance();
        end
        drive(4'b0000, 4'b0000, 1'b1, 32'h0);
        chk("t1_busy", 64'(ifc.busy), 64'h1);
        advance();

        // T2: all requesting, no deq -> strict rotation
        do_reset();
        step(4'b1111, 4'b0000, 1'b1, 32'($urandom));
        for (int k = 0; k < 8; k++) begin
            drive(4'b1111, 4'b0000, 1'b1, 32'($urandom));
            chk("t2_rotation", 64'(ifc.req_grant), 64'(1 << (k % 4)));
            advance();
        end

        // T3: outstanding cap on requester 1, freed slot grantable next cycle
        do_reset();
        step(4'b0010, 4'b0000, 1'b1, 32'($urandom));
        for (int k = 0; k < MAX_OUT; k++) step(4'b0010, 4'b0000, 1'b1, 32'($urandom));
        drive(4'b0010, 4'b0000, 1'b1, 32'($urandom));
        chk("t3_capped", 64'(ifc.req_grant), 64'h0);
        advance();
        drive(4'b0010, 4'b0010, 1'b1, 32'($urandom));
        chk("t3_deq", 64'(ifc.rob_deq_en), 64'h1);
        chk("t3_same_cycle_no_grant", 64'(ifc.req_grant), 64'h0);
        advance();
        drive(4'b0010, 4'b0000, 1'b1, 32'($urandom));
        chk("t3_regrant", 64'(ifc.req_grant), 64'h2);
        advance();

        // T4: ROB full stalls arbitration without moving the pointer
        do_reset();
        step(4'b1111, 4'b0000, 1'b1, 32'($urandom));
        step(4'b1111, 4'b0000, 1'b1, 32'($urandom));
        step(4'b1111, 4'b0000, 1'b1, 32'($urandom));
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 4'b0000, 1'b0, 32'($urandom));
            chk("t4_full", 64'(ifc.req_grant), 64'h0);
            advance();
        end
        drive(4'b1111, 4'b0000, 1'b1, 32'($urandom));
        chk("t4_resume", 64'(ifc.req_grant), 64'h4);
        advance();

        // T5: head entry held until its owner is ready
        do_reset();
        step(4'b0000, 4'b0000, 1'b1, 32'h0);
        step(4'b0100, 4'b0000, 1'b1, 32'h005A0000);
        for (int k = 0; k < 3; k++) begin
            drive(4'b0000, 4'b1011, 1'b1, 32'h0);
            chk("t5_valid", 64'(ifc.rsp_valid), 64'h4);
            chk("t5_meta", 64'(ifc.rsp_meta), 64'h5A);
            chk("t5_hold", 64'(ifc.rob_deq_en), 64'h0);
            advance();
        end
        drive(4'b0000, 4'b0100, 1'b1, 32'h0);
        chk("t5_deq", 64'(ifc.rob_deq_en), 64'h1);
        advance();
        drive(4'b0000, 4'b0000, 1'b1, 32'h0);
        chk("t5_idle", 64'(ifc.busy), 64'h0);
        advance();

        // T6: reset mid-burst with counts 3,2,0,1
        do_reset();
        step(4'b0000, 4'b0000, 1'b1, 32'h0);
        for (int k = 0; k < 3; k++) step(4'b1011, 4'b0000, 1'b1, 32'($urandom));
        for (int k = 0; k < 2; k++) step(4'b0011, 4'b0000, 1'b1, 32'($urandom));
        step(4'b0001, 4'b0000, 1'b1, 32'($urandom));
        drive(4'b1111, 4'b1111, 1'b1, 32'($urandom));
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("t6_grant", 64'(ifc.req_grant), 64'h0);
        chk("t6_enq", 64'(ifc.rob_enq_en), 64'h0);
        chk("t6_deq", 64'(ifc.rob_deq_en), 64'h0);
        chk("t6_rsp", 64'(ifc.rsp_valid), 64'h0);
        chk("t6_busy", 64'(ifc.busy), 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step(4'b1111, 4'b0000, 1'b1, 32'($urandom));
        drive(4'b1111, 4'b0000, 1'b1, 32'($urandom));
        chk("t6_first_grant", 64'(ifc.req_grant), 64'h1);
        advance();
        drive(4'b0000, 4'b0000, 1'b1, 32'h0);
        chk("t6_busy_after", 64'(ifc.busy), 64'h1);
        advance();

        // Random traffic against the reference
        do_reset();
        for (int k = 0; k < 600; k++) begin
            step(4'($urandom), 4'($urandom), ($urandom_range(0, 9) != 0), 32'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
